// File: rtl/result_ascii_fmt_pkg.sv
// Shared constants, power-of-ten table and FSM encoding for the
// result-to-ASCII formatter of the UART calculator.
package result_ascii_fmt_pkg;

    localparam int RES_W = 33;
    localparam int NDIG  = 10;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_SEND,
        S_DONE
    } state_e;

    function automatic logic [RES_W-1:0] pow10(input logic [3:0] idx);
        logic [RES_W-1:0] p;
        case (idx)
            4'd0:    p = 33'd1;
            4'd1:    p = 33'd10;
            4'd2:    p = 33'd100;
            4'd3:    p = 33'd1000;
            4'd4:    p = 33'd10000;
            4'd5:    p = 33'd100000;
            4'd6:    p = 33'd1000000;
            4'd7:    p = 33'd10000000;
            4'd8:    p = 33'd100000000;
            4'd9:    p = 33'd1000000000;
            default: p = 33'd1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/result_ascii_fmt_if.sv
// Byte stream toward the UART transmitter: valid/ready handshake.
interface result_ascii_fmt_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/result_ascii_fmt_dec_digit_extract.sv
// Binary to decimal digits by repeated subtraction of powers of ten,
// one compare/subtract per cycle, MSD slot first.
module dec_digit_extract
    import result_ascii_fmt_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic [RES_W-1:0]         res_i,
    output logic                     neg_o,
    output logic                     last_o,
    output logic [NDIG-1:0][3:0]     dig_o
);

    logic [RES_W-1:0]     mag_q, mag_d;
    logic [3:0]           pidx_q, pidx_d;
    logic [NDIG-1:0][3:0] dig_q, dig_d;
    logic                 neg_q, neg_d;
    logic [RES_W-1:0]     pw;
    logic                 ge;

    assign pw = pow10(pidx_q);
    assign ge = (mag_q >= pw);

    // Unsigned RES_W-bit magnitude: the most negative input maps cleanly.
    always_comb begin
        mag_d  = mag_q;
        pidx_d = pidx_q;
        dig_d  = dig_q;
        neg_d  = neg_q;
        if (load_i) begin
            neg_d  = res_i[RES_W-1];
            mag_d  = res_i[RES_W-1] ? -res_i : res_i;
            pidx_d = 4'(NDIG - 1);
            dig_d  = '0;
        end else if (step_i) begin
            if (ge) begin
                mag_d         = mag_q - pw;
                dig_d[pidx_q] = dig_q[pidx_q] + 4'd1;
            end else if (pidx_q != 4'd0) begin
                pidx_d = pidx_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q  <= '0;
            pidx_q <= '0;
            dig_q  <= '0;
            neg_q  <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            pidx_q <= pidx_d;
            dig_q  <= dig_d;
            neg_q  <= neg_d;
        end
    end

    assign last_o = step_i && !ge && (pidx_q == 4'd0);
    assign neg_o  = neg_q;
    assign dig_o  = dig_q;

endmodule

// File: rtl/result_ascii_fmt.sv
// Captures an ALU result, formats it as signed decimal ASCII and
// streams the line byte by byte to the UART transmitter.
module result_ascii_fmt
    import result_ascii_fmt_pkg::*;
#(
    parameter bit CRLF_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RES_W-1:0]   calc_res_i,
    input  logic               alu_done_i,
    output logic               busy_o,
    output logic               fmt_done_o,
    result_ascii_fmt_if.master tx
);

    // Send slots: 0 '-', 1..NDIG digits MSD..LSD, then CR, LF.
    localparam logic [3:0] LAST_SP = CRLF_EN ? 4'(NDIG + 2) : 4'(NDIG);

    state_e               state_q, state_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic [3:0]           sp_q, sp_d;
    logic                 neg;
    logic                 last;
    logic [NDIG-1:0][3:0] dig;
    logic [3:0]           msd;
    logic [3:0]           first_sp;
    logic [7:0]           byte_c;

    dec_digit_extract u_dig (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == S_LOAD),
        .step_i (state_q == S_CONV),
        .res_i  (res_q),
        .neg_o  (neg),
        .last_o (last),
        .dig_o  (dig)
    );

    always_comb begin
        msd = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig[i] != 4'd0) msd = 4'(i);
        end
    end

    assign first_sp = 4'(NDIG) - msd;

    always_comb begin
        byte_c = ASCII_LF;
        unique case (1'b1)
            (sp_q == 4'd0):
                byte_c = ASCII_MINUS;
            (sp_q >= 4'd1 && sp_q <= 4'(NDIG)):
                byte_c = ASCII_0 + {4'd0, dig[4'(NDIG) - sp_q]};
            (sp_q == 4'(NDIG + 1)):
                byte_c = ASCII_CR;
            default:
                byte_c = ASCII_LF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sp_d    = sp_q;
        unique case (state_q)
            S_IDLE: begin
                if (alu_done_i) begin
                    res_d   = calc_res_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_CONV;
            S_CONV: begin
                if (last) begin
                    sp_d    = neg ? 4'd0 : first_sp;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx.ready) begin
                    if (sp_q == LAST_SP) state_d = S_DONE;
                    else if (sp_q == 4'd0) sp_d = first_sp;
                    else sp_d = sp_q + 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sp_q    <= sp_d;
        end
    end

    assign tx.valid   = (state_q == S_SEND);
    assign tx.data    = (state_q == S_SEND) ? byte_c : 8'h00;
    assign busy_o     = (state_q != S_IDLE);
    assign fmt_done_o = (state_q == S_DONE);

endmodule
